// File: rtl/ram_resp_if.sv
// Processor RAM request port between a requester (master) and a memory responder (slave).
interface ram_resp_if;
  logic [23:0] ram_addr;
  logic [15:0] ram_wr_data;
  logic        ram_wr_en;
  logic        ram_rd_en;
  logic [15:0] ram_rd_data;
  logic        ram_busy;
  logic        ram_rd_ready;
  logic        ram_rd_ack;
  logic        oob_err;

  modport master (
    output ram_addr, ram_wr_data, ram_wr_en, ram_rd_en, ram_rd_ack,
    input  ram_rd_data, ram_busy, ram_rd_ready, oob_err
  );

  modport slave (
    input  ram_addr, ram_wr_data, ram_wr_en, ram_rd_en, ram_rd_ack,
    output ram_rd_data, ram_busy, ram_rd_ready, oob_err
  );
endinterface

// File: rtl/ram_resp_bram.sv
// Block-RAM responder for the processor RAM port: one request at a time,
// programmable read/write latency, out-of-range detection on the upper address bits.
module ram_resp_bram #(
  parameter int unsigned MEM_AW   = 10,
  parameter int unsigned RD_LAT   = 3,
  parameter int unsigned WR_LAT   = 2,
  parameter logic [15:0] OOB_DATA = 16'hDEAD
) (
  input  logic       clk,
  input  logic       rst_n,
  ram_resp_if.slave  bus
);

  localparam int unsigned MAX_LAT = (RD_LAT > WR_LAT) ? RD_LAT : WR_LAT;
  localparam int unsigned CNT_W   = $clog2(MAX_LAT + 1);
  localparam logic [CNT_W-1:0] RD_LOAD = CNT_W'(RD_LAT - 1);
  localparam logic [CNT_W-1:0] WR_LOAD = CNT_W'(WR_LAT - 1);

  typedef enum logic [1:0] {
    IDLE,
    WR_WAIT,
    RD_WAIT,
    RD_HOLD
  } state_e;

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [MEM_AW-1:0]  addr_q, addr_d;
  logic [15:0]        wdata_q, wdata_d;
  logic               req_oob_q, req_oob_d;
  logic               busy_q, busy_d;
  logic               rd_ready_q, rd_ready_d;
  logic               oob_err_q, oob_err_d;
  logic [15:0]        rd_data_q;
  logic               mem_we;
  logic               rd_load;
  logic               req_valid;
  logic               addr_oob;

  logic [15:0] mem [2**MEM_AW];

  assign req_valid = bus.ram_wr_en | bus.ram_rd_en;
  assign addr_oob  = |bus.ram_addr[23:MEM_AW];

  // NOTE: every signal written here gets a default first, so no path can leave one unassigned and infer a latch.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    req_oob_d  = req_oob_q;
    busy_d     = busy_q;
    rd_ready_d = rd_ready_q;
    oob_err_d  = 1'b0;
    mem_we     = 1'b0;
    rd_load    = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (req_valid) begin
          addr_d    = bus.ram_addr[MEM_AW-1:0];
          wdata_d   = bus.ram_wr_data;
          req_oob_d = addr_oob;
          oob_err_d = addr_oob;
          busy_d    = 1'b1;
          // A simultaneous read is dropped: the write owns this slot.
          if (bus.ram_wr_en) begin
            state_d = WR_WAIT;
            cnt_d   = WR_LOAD;
          end else begin
            state_d = RD_WAIT;
            cnt_d   = RD_LOAD;
          end
        end
      end
      WR_WAIT: begin
        if (cnt_q == '0) begin
          mem_we  = ~req_oob_q;
          busy_d  = 1'b0;
          state_d = IDLE;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      RD_WAIT: begin
        if (cnt_q == '0) begin
          rd_load    = 1'b1;
          rd_ready_d = 1'b1;
          state_d    = RD_HOLD;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      RD_HOLD: begin
        if (bus.ram_rd_ack) begin
          rd_ready_d = 1'b0;
          busy_d     = 1'b0;
          state_d    = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      addr_q     <= '0;
      wdata_q    <= '0;
      req_oob_q  <= 1'b0;
      busy_q     <= 1'b0;
      rd_ready_q <= 1'b0;
      oob_err_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      req_oob_q  <= req_oob_d;
      busy_q     <= busy_d;
      rd_ready_q <= rd_ready_d;
      oob_err_q  <= oob_err_d;
    end
  end

  // NOTE: the array has no reset so it maps onto block RAM; contents survive rst_n.
  always_ff @(posedge clk) begin
    if (mem_we) begin
      mem[addr_q] <= wdata_q;
    end
  end

  // Registered read port; the value is held until the next read completes.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_data_q <= '0;
    end else if (rd_load) begin
      rd_data_q <= req_oob_q ? OOB_DATA : mem[addr_q];
    end
  end

  assign bus.ram_rd_data  = rd_data_q;
  assign bus.ram_busy     = busy_q;
  assign bus.ram_rd_ready = rd_ready_q;
  assign bus.oob_err      = oob_err_q;

endmodule

// File: tb/tb_ram_resp_bram.sv
// Self-checking bench for ram_resp_bram: table of requests plus hand-built
// sequences for hold, early ack, simultaneous enables, busy-time enables and reset.
module tb_ram_resp_bram;

  localparam int RD_LAT = 3;
  localparam int WR_LAT = 2;

  logic clk = 1'b0;
  logic rst_n = 1'b0;

  ram_resp_if bus ();

  ram_resp_bram #(
    .MEM_AW  (10),
    .RD_LAT  (RD_LAT),
    .WR_LAT  (WR_LAT),
    .OOB_DATA(16'hDEAD)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit          wr;
    logic [23:0] addr;
    logic [15:0] data;  // write data, or expected read data
    bit          oob;
  } vec_t;

  vec_t        vecs[10];
  logic [15:0] exp_q[$];
  int          total = 0;
  int          bad = 0;
  int          rises = 0;
  logic        busy_prev = 1'b0;

  always @(posedge clk) begin
    #1;
    if (bus.ram_busy && !busy_prev) rises++;
    busy_prev = bus.ram_busy;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_write(input logic [23:0] addr, input logic [15:0] data,
                          input bit exp_oob, input bit both);
    int   n;
    logic rdy_seen;
    logic oob_late;
    bus.ram_addr    = addr;
    bus.ram_wr_data = data;
    bus.ram_wr_en   = 1'b1;
    bus.ram_rd_en   = both;
    tick();
    bus.ram_wr_en = 1'b0;
    bus.ram_rd_en = 1'b0;
    check("wr_accept_busy", bus.ram_busy, 1);
    check("wr_oob", bus.oob_err, exp_oob);
    n = 0;
    rdy_seen = 1'b0;
    oob_late = 1'b0;
    while (bus.ram_busy && n < 100) begin
      n++;
      tick();
      rdy_seen |= bus.ram_rd_ready;
      oob_late |= bus.oob_err;
    end
    check("wr_busy_cycles", n, WR_LAT);
    if (both) begin
      repeat (RD_LAT + 2) begin
        tick();
        rdy_seen |= bus.ram_rd_ready;
      end
    end
    check("wr_no_rd_ready", rdy_seen, 0);
    check("wr_oob_pulse", oob_late, 0);
  endtask

  task automatic do_read(input logic [23:0] addr, input logic [15:0] exp, input bit exp_oob,
                         input int hold, input bit early_ack);
    int          lat;
    logic        oob_late;
    logic        stable;
    logic [15:0] held;
    logic [15:0] want;
    exp_q.push_back(exp);
    bus.ram_addr  = addr;
    bus.ram_rd_en = 1'b1;
    tick();
    bus.ram_rd_en = 1'b0;
    check("rd_accept_busy", bus.ram_busy, 1);
    check("rd_oob", bus.oob_err, exp_oob);
    lat = 0;
    oob_late = 1'b0;
    if (early_ack) begin
      bus.ram_rd_ack = 1'b1;
      tick();
      bus.ram_rd_ack = 1'b0;
      lat = 1;
      oob_late |= bus.oob_err;
    end
    while (!bus.ram_rd_ready && lat < 100) begin
      tick();
      lat++;
      oob_late |= bus.oob_err;
    end
    check("rd_latency", lat, RD_LAT);
    check("rd_oob_pulse", oob_late, 0);
    if (exp_q.size() == 0) begin
      check("rd_scoreboard_empty", exp_q.size(), 1);
    end else begin
      want = exp_q.pop_front();
      check("rd_data", bus.ram_rd_data, want);
    end
    held = bus.ram_rd_data;
    stable = 1'b1;
    repeat (hold) begin
      tick();
      stable &= bus.ram_rd_ready & bus.ram_busy & (bus.ram_rd_data == held);
    end
    check("rd_hold_stable", stable, 1);
    bus.ram_rd_ack = 1'b1;
    tick();
    bus.ram_rd_ack = 1'b0;
    check("rd_ack_ready", bus.ram_rd_ready, 0);
    check("rd_ack_busy", bus.ram_busy, 0);
    check("rd_data_held", bus.ram_rd_data, held);
  endtask

  initial begin
    int          r0;
    logic [15:0] want;

    vecs[0] = '{1'b1, 24'h000010, 16'hBEEF, 1'b0};
    vecs[1] = '{1'b0, 24'h000010, 16'hBEEF, 1'b0};
    vecs[2] = '{1'b1, 24'h0003FF, 16'h7777, 1'b0};
    vecs[3] = '{1'b0, 24'h0003FF, 16'h7777, 1'b0};
    vecs[4] = '{1'b1, 24'h000000, 16'h0F0F, 1'b0};
    vecs[5] = '{1'b1, 24'h000400, 16'h5555, 1'b1};
    vecs[6] = '{1'b0, 24'h000000, 16'h0F0F, 1'b0};
    vecs[7] = '{1'b0, 24'h000400, 16'hDEAD, 1'b1};
    vecs[8] = '{1'b1, 24'h000030, 16'h3030, 1'b0};
    vecs[9] = '{1'b0, 24'hFFFFFF, 16'hDEAD, 1'b1};

    bus.ram_addr    = '0;
    bus.ram_wr_data = '0;
    bus.ram_wr_en   = 1'b0;
    bus.ram_rd_en   = 1'b0;
    bus.ram_rd_ack  = 1'b0;

    repeat (3) tick();
    rst_n = 1'b1;
    tick();
    check("rst_busy", bus.ram_busy, 0);
    check("rst_rd_ready", bus.ram_rd_ready, 0);
    check("rst_rd_data", bus.ram_rd_data, 0);
    check("rst_oob", bus.oob_err, 0);

    foreach (vecs[i]) begin
      if (vecs[i].wr) do_write(vecs[i].addr, vecs[i].data, vecs[i].oob, 1'b0);
      else            do_read(vecs[i].addr, vecs[i].data, vecs[i].oob, 0, 1'b0);
      tick();
    end

    // Long hold without ack.
    do_read(24'h000010, 16'hBEEF, 1'b0, 20, 1'b0);
    tick();

    // Both enables: write wins, no read response.
    do_write(24'h000020, 16'h1234, 1'b0, 1'b1);
    do_read(24'h000020, 16'h1234, 1'b0, 0, 1'b0);
    tick();

    // Ack during RD_WAIT must be ignored.
    do_read(24'h000010, 16'hBEEF, 1'b0, 3, 1'b1);
    tick();

    // Enables toggled while busy: exactly one acceptance, mem unchanged.
    r0 = rises;
    exp_q.push_back(16'h1234);
    bus.ram_addr  = 24'h000020;
    bus.ram_rd_en = 1'b1;
    tick();
    for (int i = 0; i < 6; i++) begin
      bus.ram_wr_data = 16'hFFFF;
      bus.ram_wr_en   = i[0];
      bus.ram_rd_en   = ~i[0];
      tick();
    end
    bus.ram_wr_en = 1'b0;
    bus.ram_rd_en = 1'b0;
    check("tog_rd_ready", bus.ram_rd_ready, 1);
    want = exp_q.pop_front();
    check("tog_rd_data", bus.ram_rd_data, want);
    bus.ram_rd_ack = 1'b1;
    tick();
    bus.ram_rd_ack = 1'b0;
    check("tog_busy_fall", bus.ram_busy, 0);
    tick();
    check("tog_busy_rises", rises - r0, 1);
    do_read(24'h000020, 16'h1234, 1'b0, 0, 1'b0);
    tick();

    // Reset one cycle after a write is accepted: write is aborted.
    bus.ram_addr    = 24'h000030;
    bus.ram_wr_data = 16'hAAAA;
    bus.ram_wr_en   = 1'b1;
    tick();
    bus.ram_wr_en = 1'b0;
    tick();
    rst_n = 1'b0;
    #1;
    check("mid_rst_busy", bus.ram_busy, 0);
    check("mid_rst_rd_ready", bus.ram_rd_ready, 0);
    check("mid_rst_rd_data", bus.ram_rd_data, 0);
    check("mid_rst_oob", bus.oob_err, 0);
    repeat (2) tick();
    rst_n = 1'b1;
    tick();
    do_read(24'h000030, 16'h3030, 1'b0, 0, 1'b0);

    check("scoreboard_drained", exp_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, bad=%0d", bad);
    $fatal(1, "watchdog");
  end

endmodule
